// File: rtl/rf_wb_sched_if.sv
// Bus bundle for rf_wb_sched: ID issue port, pipeline WB port, long-unit port and RF write port.
// The slave modport is the scheduler side; master is the environment side.
interface rf_wb_sched_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LU_MAX = 4
);
  localparam int OUT_W = $clog2(LU_MAX + 1);

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs;
  logic [ADDR_W-1:0] issue_rt;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_we;
  logic              issue_long;
  logic              stall;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Long unit handshake: a result transfers at a posedge where lu_valid and
  // lu_ready are both high; the producer holds addr/data stable until then.
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;

  logic              RFWr;
  logic [ADDR_W-1:0] RF_address_write;
  logic [DATA_W-1:0] RF_data_write;

  logic [OUT_W-1:0]  dbg_outstanding;

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_we, issue_long,
    input  wb_we, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    output stall, lu_ready, RFWr, RF_address_write, RF_data_write, dbg_outstanding
  );

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_we, issue_long,
    output wb_we, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    input  stall, lu_ready, RFWr, RF_address_write, RF_data_write, dbg_outstanding
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: merges WB and long-unit results, tracks pending long destinations.
// Optional macro RF_WB_SCHED_LU_BYPASS_EN lets a long result skip an empty FIFO straight to the RF port.
module rf_wb_sched #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int LU_MAX     = 4
) (
  input  logic          clk,
  input  logic          resetn,
  rf_wb_sched_if.slave  bus
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(LU_MAX + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [OUT_W-1:0] LU_MAX_C = OUT_W'(LU_MAX);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;

  logic              fifo_empty;
  logic              lu_ready;
  logic              lu_hs;
  logic              bypass;
  logic              drain;
  logic              push;
  logic              done;
  logic [ADDR_W-1:0] done_addr;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              stall;
  logic              issue_set;

  assign fifo_empty = (count_q == '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign lu_ready   = resetn & (count_q < DEPTH_C);
  assign lu_hs      = bus.lu_valid & lu_ready;

`ifdef RF_WB_SCHED_LU_BYPASS_EN
  assign bypass = resetn & fifo_empty & ~bus.wb_we & bus.lu_valid;
`else
  assign bypass = 1'b0;
`endif

  // WB always wins the port; a drain only happens on cycles WB leaves idle.
  assign drain     = resetn & ~bus.wb_we & ~fifo_empty;
  assign push      = lu_hs & ~bypass;
  assign done      = drain | bypass;
  assign done_addr = drain ? head_addr : bus.lu_addr;

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (resetn) begin
      if (bus.wb_we) begin
        sel_valid = 1'b1;
        sel_addr  = bus.wb_addr;
        sel_data  = bus.wb_data;
      end else if (!fifo_empty) begin
        sel_valid = 1'b1;
        sel_addr  = head_addr;
        sel_data  = head_data;
      end else if (bypass) begin
        sel_valid = 1'b1;
        sel_addr  = bus.lu_addr;
        sel_data  = bus.lu_data;
      end
    end
  end

  assign stall = resetn & bus.issue_valid &
                 (pending_q[bus.issue_rs] |
                  pending_q[bus.issue_rt] |
                  (bus.issue_we & pending_q[bus.issue_rd]) |
                  (bus.issue_long & (outstanding_q == LU_MAX_C)));

  assign issue_set = bus.issue_valid & ~stall & bus.issue_we & bus.issue_long &
                     (bus.issue_rd != '0);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pending_d     = pending_q;
    outstanding_d = outstanding_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (drain) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, drain})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // WAW stalls guarantee a set and a clear never hit the same register together.
    if (done) pending_d[done_addr] = 1'b0;
    if (issue_set) pending_d[bus.issue_rd] = 1'b1;

    // A result nobody issued as long must not wrap the counter below zero.
    if (issue_set && !(done && outstanding_q != '0)) begin
      outstanding_d = outstanding_q + OUT_ONE;
    end else if (!issue_set && done && outstanding_q != '0) begin
      outstanding_d = outstanding_q - OUT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.lu_data;
      fifo_addr_q[wr_ptr_q] <= bus.lu_addr;
    end
  end

  assign bus.stall            = stall;
  assign bus.lu_ready         = lu_ready;
  assign bus.RFWr             = sel_valid & (sel_addr != '0);
  assign bus.RF_address_write = sel_addr;
  assign bus.RF_data_write    = sel_data;
  assign bus.dbg_outstanding  = outstanding_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched: RF writes are scoreboarded by a negedge monitor,
// stall / lu_ready / outstanding are checked inline against hand-computed values.
module tb_rf_wb_sched;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rf_wb_sched_if #(.DATA_W(32), .ADDR_W(5), .LU_MAX(4)) bus ();

  rf_wb_sched #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .LU_MAX(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [36:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (bus.RFWr !== 1'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rf_write_unexpected: got addr %0d data 0x%0h, expected no write",
                 bus.RF_address_write, bus.RF_data_write);
      end else begin
        e = exp_q.pop_front();
        if ({bus.RF_address_write, bus.RF_data_write} !== e) begin
          fails++;
          $display("FAIL rf_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   bus.RF_address_write, bus.RF_data_write, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rs = '0; bus.issue_rt = '0; bus.issue_rd = '0;
    bus.issue_we = 1'b0; bus.issue_long = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic we, input logic lng);
    bus.issue_valid = 1'b1; bus.issue_rs = rs; bus.issue_rt = rt; bus.issue_rd = rd;
    bus.issue_we = we; bus.issue_long = lng;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    // Reset with both producers active
    bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h55;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd3; bus.lu_data = 32'h77;
    issue(5'd0, 5'd0, 5'd1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(); @(negedge clk);
      check("rst_rfwr", bus.RFWr, 1'b0);
      check("rst_lu_ready", bus.lu_ready, 1'b0);
      check("rst_stall", bus.stall, 1'b0);
    end
    cyc(); idle(); resetn = 1'b1;
    @(negedge clk);
    check("post_rst_lu_ready", bus.lu_ready, 1'b1);
    check("post_rst_outstanding", bus.dbg_outstanding, 3'd0);

    // RAW on a long destination
    cyc(); issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    @(negedge clk); check("raw_issue_stall", bus.stall, 1'b0);
    cyc(); issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk); check("raw_stall", bus.stall, 1'b1);
    check("raw_outstanding", bus.dbg_outstanding, 3'd1);
    cyc(); bus.lu_valid = 1'b1; bus.lu_addr = 5'd5; bus.lu_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk); check("raw_stall_hs", bus.stall, 1'b1);
    check("raw_lu_ready", bus.lu_ready, 1'b1);
    cyc(); bus.lu_valid = 1'b0;
    @(negedge clk); check("raw_stall_drain", bus.stall, 1'b1);
    check("raw_drain_rfwr", bus.RFWr, 1'b1);
    cyc();
    @(negedge clk); check("raw_release", bus.stall, 1'b0);
    check("raw_outstanding_done", bus.dbg_outstanding, 3'd0);
    cyc(); idle();

    // WB beats a waiting FIFO head
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = 32'h22;
    cyc(); idle(); bus.wb_we = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h11;
    exp_q.push_back({5'd3, 32'h11});
    exp_q.push_back({5'd7, 32'h22});
    @(negedge clk); check("prio_wb_addr", bus.RF_address_write, 5'd3);
    cyc(); bus.wb_we = 1'b0;
    @(negedge clk); check("prio_drain_addr", bus.RF_address_write, 5'd7);
    cyc();
    @(negedge clk); check("prio_empty_rfwr", bus.RFWr, 1'b0);

    // Starvation: WB busy for 10 cycles, three long results offered
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus.wb_we = 1'b1; bus.wb_addr = 5'(10 + i); bus.wb_data = 32'h100 + i;
      exp_q.push_back({5'(10 + i), 32'h100 + i});
      if (i < 3) begin
        bus.lu_valid = 1'b1; bus.lu_addr = 5'(20 + i); bus.lu_data = 32'hA1 + i;
      end
      @(negedge clk);
      if (i == 1) check("starve_ready_2nd", bus.lu_ready, 1'b1);
      if (i == 2) check("starve_ready_3rd", bus.lu_ready, 1'b0);
      if (i == 9) check("starve_ready_end", bus.lu_ready, 1'b0);
    end
    exp_q.push_back({5'd20, 32'hA1});
    exp_q.push_back({5'd21, 32'hA2});
    exp_q.push_back({5'd22, 32'hA3});
    cyc(); bus.wb_we = 1'b0;
    @(negedge clk); check("starve_ready_full", bus.lu_ready, 1'b0);
    cyc();
    @(negedge clk); check("starve_ready_free", bus.lu_ready, 1'b1);
    cyc(); bus.lu_valid = 1'b0;
    @(negedge clk);
    cyc();
    @(negedge clk); check("starve_done_rfwr", bus.RFWr, 1'b0);

    // Register 0 is never written and never pending
    cyc(); idle(); bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    @(negedge clk); check("r0_wb_rfwr", bus.RFWr, 1'b0);
    cyc(); idle(); issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    @(negedge clk); check("r0_issue_stall", bus.stall, 1'b0);
    cyc(); issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    @(negedge clk); check("r0_pending_stall", bus.stall, 1'b0);
    check("r0_outstanding", bus.dbg_outstanding, 3'd0);

    // Outstanding limit
    for (int i = 1; i <= 4; i++) begin
      cyc(); issue(5'd0, 5'd0, 5'(i), 1'b1, 1'b1);
      @(negedge clk); check("lim_issue_stall", bus.stall, 1'b0);
    end
    cyc(); issue(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
    @(negedge clk); check("lim_stall", bus.stall, 1'b1);
    check("lim_outstanding", bus.dbg_outstanding, 3'd4);
    cyc(); bus.lu_valid = 1'b1; bus.lu_addr = 5'd1; bus.lu_data = 32'h1111;
    exp_q.push_back({5'd1, 32'h1111});
    @(negedge clk); check("lim_stall_hs", bus.stall, 1'b1);
    cyc(); bus.lu_valid = 1'b0;
    @(negedge clk); check("lim_stall_drain", bus.stall, 1'b1);
    cyc();
    @(negedge clk); check("lim_release", bus.stall, 1'b0);
    cyc(); idle();
    @(negedge clk); check("lim_outstanding_after", bus.dbg_outstanding, 3'd4);
    cyc(); issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    @(negedge clk); check("waw_stall", bus.stall, 1'b1);
    cyc(); idle();

    @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler and scoreboard for the single-write-port general register file.
- Merges two producers onto one RF write port:
  - In-order pipeline WB stage: highest priority, never back-pressured.
  - Long-latency unit (divider / multi-cycle multiply): valid/ready handshake, results buffered in a small FIFO.
- Keeps a per-register pending scoreboard for long-latency destinations and raises a combinational stall to the ID stage on RAW/WAW hazards or when too many long ops are outstanding.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- FIFO_DEPTH, 2, long-unit result buffer entries (power of two, >=2)
- LU_MAX, 4, maximum long ops issued but not yet written back

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  synchronous active-low reset
- issue_valid  in  1  ID stage presents an instruction this cycle
- issue_rs  in  ADDR_W  source register 1
- issue_rt  in  ADDR_W  source register 2
- issue_rd  in  ADDR_W  destination register
- issue_we  in  1  instruction writes issue_rd
- issue_long  in  1  destination produced by long-latency unit
- stall  out  1  combinational; ID must hold instruction
- wb_we  in  1  pipeline WB write request
- wb_addr  in  ADDR_W  WB destination
- wb_data  in  DATA_W  WB data
- lu_valid  in  1  long unit result valid
- lu_addr  in  ADDR_W  long unit destination
- lu_data  in  DATA_W  long unit result
- lu_ready  out  1  FIFO can accept; transfer = lu_valid & lu_ready at posedge
- RFWr  out  1  RF write enable (combinational)
- RF_address_write  out  ADDR_W  RF write address
- RF_data_write  out  DATA_W  RF write data

Behaviour:
- Reset (resetn low at posedge):
  - FIFO emptied, count=0, pending[]=0, outstanding=0.
  - While resetn is low: RFWr=0, stall=0, lu_ready=0.
  - Reset mid-operation discards buffered results and pending bits.
- Write-port mux, combinational:
  - wb_we=1: port driven by wb_addr/wb_data.
  - else FIFO non-empty: port driven by the FIFO head ("drain"); head pops at posedge.
  - else RFWr=0; address and data are don't-care, driven 0.
- RFWr is forced 0 whenever the selected address is 0. A drain to address 0 still pops.
- FIFO:
  - Push on lu handshake.
  - lu_ready = (count<FIFO_DEPTH).
  - Simultaneous push and pop when full is not allowed: ready is already low when full.
  - Push+pop when non-full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - Accepted issue = issue_valid & ~stall.
  - On an accepted issue with issue_we & issue_long & rd!=0: pending[rd] set, outstanding++.
  - On a drain cycle: pending[head.addr] cleared, outstanding--.
  - Set and clear of the same register in one cycle cannot occur, because WAW stalls.
  - Simultaneous inc and dec: outstanding unchanged.
- stall = issue_valid & (any of):
  - pending[rs]
  - pending[rt]
  - issue_we & pending[rd]
  - issue_long & outstanding==LU_MAX
- pending[0] is never set.
- Latency: a long result reaches the RF no earlier than the cycle after its handshake, and later if WB is busy. Its pending bit clears at the posedge ending the drain cycle, so a dependent instruction issues the next cycle.
- Starvation: continuous wb_we holds drains off. The FIFO fills, lu_ready drops, the long unit waits. No data loss.

Optional Feature:
- Macro: RF_WB_SCHED_LU_BYPASS_EN.
- Defined: when FIFO is empty, wb_we=0 and lu_valid=1, the lu result drives the RF port in the same cycle.
  - Handshake completes with no push.
  - Pending bit clears and outstanding decrements at that posedge.
  - lu_ready stays (count<FIFO_DEPTH).
- Undefined: every lu result goes through the FIFO, minimum 1 cycle latency.

Test Plan:
- Reset held 2 cycles with lu_valid=1, wb_we=1 -> RFWr=0, lu_ready=0, stall=0; after release lu_ready=1, outstanding=0.
- Issue long rd=5, then issue rs=5 -> stall=1 until lu result (addr 5, data 0xDEADBEEF) drains: RFWr=1, addr 5, data 0xDEADBEEF; stall=0 the next cycle.
- wb_we=1 (addr 3, 0x11) same cycle as FIFO head (addr 7, 0x22) -> port shows addr 3/0x11; next cycle with wb_we=0 port shows addr 7/0x22.
- wb_we held high 10 cycles with 3 lu results offered -> 2 accepted, lu_ready=0 on the third; after wb_we drops, the two drain in order, then the third is accepted.
- Issue 4 long ops to r1..r4 with no results returned -> fifth long issue stalls (outstanding==LU_MAX); one drain releases it.
- WB write to addr 0 data 0xFFFFFFFF -> RFWr=0; issue long rd=0 -> no pending bit, outstanding unchanged.
